// File: rtl/seq_detector_prog_if.sv
// Bus bundle for the programmable serial pattern detector: configuration,
// serial data input, counter clear and the detector's status outputs.
interface seq_detector_prog_if #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 8
);
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               in_valid;
    logic               in_bit;
    logic               cnt_clr;
    logic               detected;
    logic [CNT_W-1:0]   match_count;
    logic               armed;

    // Driver side: the block that programs and feeds the detector
    modport master (
        output cfg_load, cfg_pattern, cfg_len, cfg_overlap,
        output in_valid, in_bit, cnt_clr,
        input  detected, match_count, armed
    );

    // Detector side
    modport slave (
        input  cfg_load, cfg_pattern, cfg_len, cfg_overlap,
        input  in_valid, in_bit, cnt_clr,
        output detected, match_count, armed
    );
endinterface

// File: rtl/seq_detector_prog.sv
// Run-time programmable serial bit-pattern detector. A pattern of 1..MAX_LEN
// bits is compared against a sliding window of the most recent input bits;
// a match pulses detected one cycle later and bumps a saturating counter.
module seq_detector_prog #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 8
) (
    input logic              clk,
    input logic              rst,
    seq_detector_prog_if.slave sl
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_q;
    logic [MAX_LEN-1:0] pattern_q;
    logic [LEN_W-1:0]   len_q;
    logic               overlap_q;
    logic [MAX_LEN-2:0] hist_q;
    logic [LEN_W-1:0]   fill_q;
    logic               detected_q;
    logic [CNT_W-1:0]   count_q;

    // Window seen this cycle: previous history with the new bit at the bottom
    logic [MAX_LEN-1:0] window_d;
    logic [MAX_LEN-1:0] len_mask;
    logic [LEN_W:0]     fill_inc;
    logic [LEN_W-1:0]   fill_d;
    logic               match_hit;
    logic               cfg_legal;

    assign window_d = {hist_q, sl.in_bit};

    // Only the low len_q bits of the window and the pattern take part
    genvar gi;
    generate
        for (gi = 0; gi < MAX_LEN; gi++) begin : g_mask
            assign len_mask[gi] = ({1'b0, len_q} > (LEN_W+1)'(gi));
        end
    endgenerate

    // fill_inc carries an extra bit so fill+1 never wraps before the compare
    assign fill_inc  = {1'b0, fill_q} + (LEN_W+1)'(1);
    assign fill_d    = (fill_inc >= {1'b0, len_q}) ? len_q : fill_inc[LEN_W-1:0];
    assign cfg_legal = (sl.cfg_len != '0) && ({1'b0, sl.cfg_len} <= (LEN_W+1)'(MAX_LEN));

    // Match needs enough buffered bits and equality on the active window bits
    always_comb begin
        match_hit = 1'b0;
        if ((state_q == RUN) && sl.in_valid && (fill_inc >= {1'b0, len_q})) begin
            match_hit = (((window_d ^ pattern_q) & len_mask) == '0);
        end
    end

    // Control FSM with config latch, history/fill datapath and match counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pattern_q  <= '0;
            len_q      <= '0;
            overlap_q  <= 1'b0;
            hist_q     <= '0;
            fill_q     <= '0;
            detected_q <= 1'b0;
            count_q    <= '0;
        end else if (sl.cfg_load) begin
            // Reprogramming discards any partial match and the input bit
            pattern_q  <= sl.cfg_pattern;
            len_q      <= sl.cfg_len;
            overlap_q  <= sl.cfg_overlap;
            hist_q     <= '0;
            fill_q     <= '0;
            detected_q <= 1'b0;
            count_q    <= '0;
            state_q    <= cfg_legal ? RUN : IDLE;
        end else begin
            detected_q <= match_hit;
            if ((state_q == RUN) && sl.in_valid) begin
                hist_q <= window_d[MAX_LEN-2:0];
                // Non-overlap mode forces the next match to use fresh bits
                fill_q <= (match_hit && !overlap_q) ? '0 : fill_d;
            end
            // A match coinciding with a clear is counted after the clear
            if (sl.cnt_clr) begin
                count_q <= match_hit ? CNT_W'(1) : '0;
            end else if (match_hit && (count_q != {CNT_W{1'b1}})) begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

    assign sl.detected    = detected_q;
    assign sl.match_count = count_q;
    assign sl.armed       = (state_q == RUN);

endmodule
